// File: rtl/frame_rr_sched.sv
// Round-robin frame scheduler: grants one AXI-Stream requester per frame of
// cnt_limit+1 beats and passes its beats through to a shared count/align stage.
module frame_rr_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                           clk,
    input  logic                           sync_reset,
    input  logic                           enable,
    input  logic [NUM_REQ-1:0]             s_axis_tvalid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  s_axis_tdata,
    output logic [NUM_REQ-1:0]             s_axis_tready,
    input  logic [NUM_REQ*16-1:0]          req_cnt_limit,
    output logic                           m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [ID_WIDTH-1:0]            m_axis_tid,
    output logic                           start_sig,
    output logic [15:0]                    cnt_limit,
    output logic                           frame_done,
    output logic                           busy
);

    localparam int unsigned        NSLOT    = 2 ** ID_WIDTH;
    localparam int unsigned        NREQ_U   = NUM_REQ;
    localparam logic [ID_WIDTH:0]  NREQ_W   = (ID_WIDTH + 1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t               state_q, state_d;
    logic [ID_WIDTH-1:0]  grant_q, grant_d;
    logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          lim_q, lim_d;
    logic                 done_q, done_d;

    logic [ID_WIDTH-1:0]  sel;
    logic                 sel_found;
    logic [ID_WIDTH:0]    cand;
    logic                 busy_w;
    logic                 hs;
    logic                 last_w;

    // Requester buses padded out to the full ID range so any grant index is a legal select.
    logic [NSLOT-1:0]      valid_pad;
    logic [DATA_WIDTH-1:0] data_arr [NSLOT];
    logic [15:0]           lim_arr  [NSLOT];

    generate
        for (genvar g = 0; g < NSLOT; g++) begin : g_slot
            if (g < NUM_REQ) begin : g_real
                assign valid_pad[g] = s_axis_tvalid[g];
                assign data_arr[g]  = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
                assign lim_arr[g]   = req_cnt_limit[g*16 +: 16];
            end else begin : g_pad
                assign valid_pad[g] = 1'b0;
                assign data_arr[g]  = '0;
                assign lim_arr[g]   = '0;
            end
        end

        for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
            assign s_axis_tready[g] = busy_w & m_axis_tready & (grant_q == ID_WIDTH'(g));
        end
    endgenerate

    // First valid requester scanning upward from ptr+1, wrapping at NUM_REQ.
    always_comb begin
        sel       = ptr_q;
        sel_found = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ_U; i++) begin
            cand = {1'b0, ptr_q} + (ID_WIDTH + 1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!sel_found && valid_pad[cand[ID_WIDTH-1:0]]) begin
                sel_found = 1'b1;
                sel       = cand[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        busy_w        = (state_q == BURST);
        m_axis_tvalid = busy_w & valid_pad[grant_q];
        m_axis_tdata  = busy_w ? data_arr[grant_q] : '0;
        m_axis_tid    = busy_w ? grant_q : '0;
        cnt_limit     = busy_w ? lim_q : '0;
        start_sig     = busy_w & (cnt_q == '0);
        last_w        = busy_w & (cnt_q == lim_q);
        m_axis_tlast  = last_w;
        busy          = busy_w;
        frame_done    = done_q;
        hs            = m_axis_tvalid & m_axis_tready;

        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && sel_found) begin
                    grant_d = sel;
                    ptr_d   = sel;
                    lim_d   = lim_arr[sel];
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (hs) begin
                    if (last_w) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= LAST_IDX;
            cnt_q   <= '0;
            lim_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_frame_rr_sched.sv
// Directed bench for frame_rr_sched: arbitration order, frame framing,
// stalls, limit latching, enable gating and mid-frame reset.
module tb_frame_rr_sched;

  logic         clk = 1'b0;
  logic         sync_reset;
  logic         enable;
  logic [3:0]   s_axis_tvalid;
  logic [127:0] s_axis_tdata;
  logic [3:0]   s_axis_tready;
  logic [63:0]  req_cnt_limit;
  logic         m_axis_tvalid;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [1:0]   m_axis_tid;
  logic         start_sig;
  logic [15:0]  cnt_limit;
  logic         frame_done;
  logic         busy;

  logic [31:0]  tdat [4];
  logic [15:0]  lim  [4];

  int checks = 0;
  int errors = 0;
  int nb;

  // {busy, tid, start_sig, tlast, frame_done} per cycle for the 3-requester rotation
  logic [5:0] exp2 [10] = '{6'b100100, 6'b100010, 6'b000001, 6'b101100, 6'b101000,
                            6'b101010, 6'b000001, 6'b110110, 6'b000001, 6'b100100};

  assign s_axis_tdata  = {tdat[3], tdat[2], tdat[1], tdat[0]};
  assign req_cnt_limit = {lim[3], lim[2], lim[1], lim[0]};

  always #5 clk = ~clk;

  frame_rr_sched #(
    .DATA_WIDTH (32),
    .NUM_REQ    (4),
    .ID_WIDTH   (2)
  ) dut (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .enable        (enable),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .req_cnt_limit (req_cnt_limit),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .start_sig     (start_sig),
    .cnt_limit     (cnt_limit),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    sync_reset    = 1'b1;
    enable        = 1'b0;
    s_axis_tvalid = 4'b0000;
    m_axis_tready = 1'b0;
    tick;
    tick;
    sync_reset = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $error("FAIL timeout waiting for test sequence to complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      tdat[i] = 32'h1111_0000 * 32'(i + 1);
      lim[i]  = 16'd0;
    end
    sync_reset    = 1'b1;
    enable        = 1'b0;
    s_axis_tvalid = 4'b0000;
    m_axis_tready = 1'b0;

    // Reset state
    do_reset;
    #1;
    chk("reset_outputs",
        {m_axis_tvalid, s_axis_tready, start_sig, m_axis_tlast, frame_done, busy, m_axis_tid, cnt_limit, m_axis_tdata},
        59'd0);

    // Single requester 0, limit 3
    do_reset;
    lim[0]        = 16'd3;
    s_axis_tvalid = 4'b0001;
    m_axis_tready = 1'b1;
    enable        = 1'b1;
    #1;
    chk("t1_idle", {busy, m_axis_tvalid}, 2'b00);
    for (int b = 0; b < 4; b++) begin
      tick;
      tdat[0] = 32'hD000_0000 + 32'(b);
      #1;
      chk("t1_beat", {m_axis_tvalid, m_axis_tid, start_sig, m_axis_tlast, s_axis_tready},
          {1'b1, 2'd0, b == 0, b == 3, 4'b0001});
      chk("t1_data", m_axis_tdata, 32'hD000_0000 + 32'(b));
      chk("t1_lim", cnt_limit, 16'd3);
    end
    tick;
    #1;
    chk("t1_done", {busy, frame_done, s_axis_tready}, 6'b010000);
    tick;
    #1;
    chk("t1_next", {busy, start_sig, frame_done, m_axis_tid}, 5'b11000);

    // Requesters 0,1,2 with limits 1,2,0 rotating
    do_reset;
    lim[0]        = 16'd1;
    lim[1]        = 16'd2;
    lim[2]        = 16'd0;
    s_axis_tvalid = 4'b0111;
    m_axis_tready = 1'b1;
    enable        = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      #1;
      chk("t2_rr", {busy, m_axis_tid, start_sig, m_axis_tlast, frame_done}, exp2[i]);
    end

    // Requester 1, limit 4, downstream ready toggling
    do_reset;
    lim[1]        = 16'd4;
    s_axis_tvalid = 4'b0010;
    enable        = 1'b1;
    tick;
    tdat[1] = 32'hB000;
    #1;
    chk("t3_stall", {m_axis_tvalid, m_axis_tid, start_sig, m_axis_tlast, s_axis_tready},
        {1'b1, 2'd1, 1'b1, 1'b0, 4'b0000});
    nb = 0;
    for (int c = 0; c < 9; c++) begin
      tick;
      m_axis_tready = (c % 2 == 0);
      tdat[1] = 32'hB000 + 32'(nb);
      #1;
      chk("t3_beat", {m_axis_tvalid, m_axis_tid, start_sig, m_axis_tlast, s_axis_tready},
          {1'b1, 2'd1, nb == 0, nb == 4, m_axis_tready ? 4'b0010 : 4'b0000});
      chk("t3_data", m_axis_tdata, 32'hB000 + 32'(nb));
      if (m_axis_tready) nb++;
    end
    tick;
    #1;
    chk("t3_done", {busy, frame_done, s_axis_tready}, 6'b010000);

    // Limit change mid-frame is ignored until the next grant
    do_reset;
    lim[3]        = 16'd5;
    s_axis_tvalid = 4'b1000;
    m_axis_tready = 1'b1;
    enable        = 1'b1;
    for (int b = 0; b < 6; b++) begin
      tick;
      if (b == 2) lim[3] = 16'd1;
      #1;
      chk("t4_beat", {busy, m_axis_tid, m_axis_tlast}, {1'b1, 2'd3, b == 5});
      chk("t4_lim", cnt_limit, 16'd5);
    end
    tick;
    #1;
    chk("t4_done", {busy, frame_done}, 2'b01);
    tick;
    #1;
    chk("t4_new", {busy, start_sig, m_axis_tlast, cnt_limit}, {3'b110, 16'd1});
    tick;
    #1;
    chk("t4_new_last", {start_sig, m_axis_tlast}, 2'b01);
    tick;
    #1;
    chk("t4_new_done", {busy, frame_done}, 2'b01);

    // enable dropped mid-frame, then re-enabled with requester 3
    do_reset;
    lim[0]        = 16'd3;
    s_axis_tvalid = 4'b0001;
    m_axis_tready = 1'b1;
    enable        = 1'b1;
    tick;
    #1;
    chk("t5_b0", {busy, m_axis_tid, start_sig}, 4'b1001);
    tick;
    enable = 1'b0;
    #1;
    chk("t5_b1", {busy, start_sig, m_axis_tlast}, 3'b100);
    tick;
    #1;
    chk("t5_b2", {busy, m_axis_tlast}, 2'b10);
    tick;
    #1;
    chk("t5_b3", {busy, m_axis_tlast}, 2'b11);
    tick;
    s_axis_tvalid = 4'b1001;
    #1;
    chk("t5_done", {busy, frame_done}, 2'b01);
    tick;
    #1;
    chk("t5_hold1", {busy, s_axis_tready, frame_done}, 6'b000000);
    tick;
    #1;
    chk("t5_hold2", {busy, m_axis_tvalid}, 2'b00);
    s_axis_tvalid = 4'b1000;
    enable        = 1'b1;
    tick;
    #1;
    chk("t5_reen", {busy, m_axis_tid, start_sig}, 4'b1111);

    // sync_reset mid-frame from requester 2
    do_reset;
    lim[2]        = 16'd7;
    lim[0]        = 16'd2;
    s_axis_tvalid = 4'b0100;
    m_axis_tready = 1'b1;
    enable        = 1'b1;
    tick;
    tick;
    tick;
    #1;
    chk("t6_b2", {busy, m_axis_tid, start_sig, m_axis_tlast, cnt_limit}, {1'b1, 2'd2, 2'b00, 16'd7});
    sync_reset = 1'b1;
    tick;
    sync_reset    = 1'b0;
    s_axis_tvalid = 4'b1111;
    #1;
    chk("t6_rst",
        {m_axis_tvalid, s_axis_tready, start_sig, m_axis_tlast, frame_done, busy, m_axis_tid, cnt_limit, m_axis_tdata},
        59'd0);
    tick;
    #1;
    chk("t6_grant", {busy, m_axis_tid, frame_done, cnt_limit}, {1'b1, 2'd0, 1'b0, 16'd2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_rr_sched.md
Name: frame_rr_sched

Overview:
- Round-robin frame scheduler that shares one count/align datapath between NUM_REQ AXI-Stream requesters.
- Grants one requester per frame and forwards its beats. The frame is cnt_limit+1 beats long, using a limit latched at grant time.
- Drives start_sig on the first beat and the frame limit/ID to the downstream count-cycle stage.
- Releases the grant after the final beat is accepted.

Parameters:
DATA_WIDTH, 32, width of each requester's data bus
NUM_REQ, 4, number of requesters (2..8)
ID_WIDTH, 2, width of grant index; NUM_REQ <= 2**ID_WIDTH

Ports:
clk  in  1  clock
sync_reset  in  1  synchronous active-high reset
enable  in  1  allow new grants; low lets the current frame finish, then holds IDLE
s_axis_tvalid  in  NUM_REQ  per-requester valid
s_axis_tdata  in  NUM_REQ*DATA_WIDTH  per-requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tready  out  NUM_REQ  per-requester ready, one-hot or zero
req_cnt_limit  in  NUM_REQ*16  per-requester frame limit (frame = limit+1 beats)
m_axis_tvalid  out  1  output valid
m_axis_tdata  out  DATA_WIDTH  output data
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  final beat of frame (beat count == latched limit)
m_axis_tid  out  ID_WIDTH  index of granted requester
start_sig  out  1  first beat of frame
cnt_limit  out  16  latched limit of current frame
frame_done  out  1  one-cycle pulse, registered, the cycle after the final beat handshake
busy  out  1  high in BURST

Behaviour:
- Reset values: state IDLE, grant 0, last-grant pointer NUM_REQ-1 (so requester 0 has first priority), beat count 0, latched limit 0. All outputs 0: m_axis_tvalid, s_axis_tready, start_sig, m_axis_tlast, frame_done, busy, m_axis_tid, cnt_limit.
- IDLE:
  - If enable and any s_axis_tvalid, select the first valid requester scanning upward from pointer+1, modulo NUM_REQ.
  - Register that index as grant and into pointer.
  - Latch its req_cnt_limit and clear the beat count; go to BURST next cycle.
  - No data moves in IDLE, so there is one bubble cycle between frames.
- BURST, combinational pass-through from the granted requester:
  - m_axis_tvalid = s_axis_tvalid[grant]
  - m_axis_tdata = its data
  - s_axis_tready[grant] = m_axis_tready; all other readies 0
  - m_axis_tid = grant; cnt_limit = latched limit
- Beat handshake = m_axis_tvalid & m_axis_tready.
- start_sig = busy & (beat count == 0); it stays asserted while stalled until the first handshake.
- m_axis_tlast = busy & (beat count == latched limit). When limit = 0, start_sig and tlast are high on the same beat.
- Each handshake increments the 16-bit beat count.
- On the handshake with tlast high:
  - next state IDLE, beat count 0
  - frame_done pulses on the following cycle
- The beat count never wraps: the maximum limit 0xFFFF gives 65536 beats, ending at count 0xFFFF.
- The grant is held for the whole frame regardless of other requesters' valid; there is no pre-emption.
- A requester dropping valid mid-frame only stalls the frame.
- req_cnt_limit changes during BURST are ignored until the next grant.
- enable deasserted mid-frame: the frame completes normally and no new grant is issued. Re-asserting enable allows a grant on that cycle.
- sync_reset mid-frame: the frame is abandoned and all state and outputs return to reset values on the next cycle. No tlast or frame_done is produced.
- Downstream-ready stall: all outputs hold and the count does not advance.

Test Plan:
- Single requester 0, limit 3, tready=1, continuous valid -> 4 beats with ID 0; start_sig on beat 0, tlast on beat 3; frame_done one cycle after beat 3; one idle cycle, then the next frame.
- Requesters 0, 1, 2 all valid, limits 1, 2, 0 -> grant order 0, 1, 2, 0...; frames of 2, 3 and 1 beats; on requester 2's single beat, start_sig and tlast are both high.
- Requester 1 limit 4, tready toggling 1,0,1,0 -> 5 handshakes; data order preserved; start_sig held across the stall before the first handshake; other s_axis_tready stay 0 throughout.
- Change req_cnt_limit of the active requester from 5 to 1 at beat 2 -> frame still 6 beats; the next frame from that requester uses 2 beats.
- enable=0 asserted at beat 1 of a 4-beat frame -> frame completes, busy falls, no grant while enable=0; re-enable with requester 3 valid -> requester 3 granted.
- sync_reset pulse at beat 2 of an 8-beat frame from requester 2 -> next cycle all outputs are 0 and no frame_done; with all requesters valid afterwards, requester 0 is granted first.
